duty_sequencer: RTL and testbench

Schedules duty-cycle codes into the 8-step thermometer waveform datapath (3-bit phase counter, pattern ROM, bit-select). It accepts a queue of duty/repeat entries over a valid/ready handshake and keeps its own phase counter. It drives the 3-bit duty select `S` and produces the waveform `O`, changing duty only on 8-cycle period boundaries so no period is ever truncated or mixed.

---
 rtl/duty_sequencer_if.sv | 13 +
 rtl/duty_sequencer.sv | 143 ++++++++++++++
 tb/tb_duty_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/duty_sequencer_if.sv
// rtl/duty_sequencer_if.sv - entry handshake bundle for duty_sequencer
// Carries one {duty, repeat} schedule entry per accepted valid/ready beat.
interface duty_sequencer_if #(
  parameter int REPEAT_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [2:0]          in_duty;
  logic [REPEAT_W-1:0] in_repeat;

  modport master (output in_valid, in_duty, in_repeat, input in_ready);
  modport slave  (input in_valid, in_duty, in_repeat, output in_ready);
endinterface

// File: rtl/duty_sequencer.sv
// rtl/duty_sequencer.sv - queued duty-cycle scheduler driving an 8-step thermometer waveform
// Optional feature macro: DUTY_HOLD_EN (keep replaying the last duty when the queue runs dry).
module duty_sequencer #(
  parameter int DEPTH    = 4,
  parameter int REPEAT_W = 4
) (
  input  logic                       CLK,
  input  logic                       CLEAR,
  input  logic                       enable,
  duty_sequencer_if.slave            in_if,
  output logic [2:0]                 S,
  output logic [2:0]                 phase,
  output logic                       O,
  output logic                       period_end,
  output logic                       underflow,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = REPEAT_W + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [RW-1:0] REM_ONE  = RW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nxt;
  logic [2:0]          phase_q, phase_nxt;
  logic [2:0]          cur_duty, duty_nxt;
  logic [RW-1:0]       remaining, rem_nxt;
  logic                uf_q, uf_nxt;
  logic                pop, push, empty;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       count;
  logic [REPEAT_W+2:0] mem [DEPTH];
  logic [2:0]          head_duty;
  logic [RW-1:0]       head_rem;
`ifdef DUTY_HOLD_EN
  logic                dry, dry_nxt;
`endif

  assign empty       = (count == '0);
  assign in_if.in_ready = (count != FULL_LVL);
  assign push        = in_if.in_valid && in_if.in_ready;
  assign head_duty   = mem[rd_ptr][REPEAT_W+2:REPEAT_W];
  assign head_rem    = {1'b0, mem[rd_ptr][REPEAT_W-1:0]} + REM_ONE;

  always_comb begin
    state_nxt = state;
    phase_nxt = phase_q;
    duty_nxt  = cur_duty;
    rem_nxt   = remaining;
    uf_nxt    = 1'b0;
    pop       = 1'b0;
`ifdef DUTY_HOLD_EN
    dry_nxt   = dry;
`endif
    case (state)
      IDLE: begin
        phase_nxt = 3'd0;
        if (enable && !empty) begin
          pop       = 1'b1;
          duty_nxt  = head_duty;
          rem_nxt   = head_rem;
          state_nxt = RUN;
        end
      end
      RUN: begin
        phase_nxt = phase_q + 3'd1;
        if (phase_q == 3'd7) begin
          if (!enable) begin
            state_nxt = IDLE;
          end else if (remaining > REM_ONE) begin
            rem_nxt = remaining - REM_ONE;
          end else if (!empty) begin
            pop      = 1'b1;
            duty_nxt = head_duty;
            rem_nxt  = head_rem;
          end else begin
`ifdef DUTY_HOLD_EN
            // One pulse per dry-out; the held duty keeps looping until a pop.
            uf_nxt  = !dry;
            dry_nxt = 1'b1;
`else
            uf_nxt    = 1'b1;
            state_nxt = IDLE;
`endif
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef DUTY_HOLD_EN
    if (pop) dry_nxt = 1'b0;
`endif
  end

  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      state     <= IDLE;
      phase_q   <= 3'd0;
      cur_duty  <= 3'd0;
      remaining <= '0;
      uf_q      <= 1'b0;
`ifdef DUTY_HOLD_EN
      dry       <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      phase_q   <= phase_nxt;
      cur_duty  <= duty_nxt;
      remaining <= rem_nxt;
      uf_q      <= uf_nxt;
`ifdef DUTY_HOLD_EN
      dry       <= dry_nxt;
`endif
    end
  end

  // Occupancy is registered, so a same-edge push is invisible to the pop decision.
  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {in_if.in_duty, in_if.in_repeat};
  end

  assign S          = cur_duty;
  assign phase      = phase_q;
  assign O          = (state == RUN) && (phase_q <= cur_duty);
  assign period_end = (state == RUN) && (phase_q == 3'd7);
  assign underflow  = uf_q;
  assign level      = count;
endmodule

// File: tb/tb_duty_sequencer.sv
// tb/tb_duty_sequencer.sv - randomized self-checking bench for duty_sequencer
// Outputs are compared every cycle against a queue-based schedule model.
module tb_duty_sequencer;
  localparam int DEPTH = 4;
  localparam int RW    = 4;

  typedef struct { logic [2:0] d; logic [RW-1:0] r; } ent_t;

  logic       CLK, CLEAR, enable;
  logic [2:0] S, phase;
  logic       O, period_end, underflow;
  logic [2:0] level;
  int         n_checks, n_errors;

  duty_sequencer_if #(.REPEAT_W(RW)) bus ();

  duty_sequencer #(.DEPTH(DEPTH), .REPEAT_W(RW)) dut (
    .CLK(CLK), .CLEAR(CLEAR), .enable(enable), .in_if(bus),
    .S(S), .phase(phase), .O(O), .period_end(period_end),
    .underflow(underflow), .level(level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: playing flag, step counter, periods left, entry queue.
  bit   m_run, m_uf, m_dry;
  int   m_ph, m_duty, m_left;
  ent_t m_q[$];
  ent_t tx_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_uf = 0; m_dry = 0; m_ph = 0; m_duty = 0; m_left = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    int   sz;
    bit   psh, uf;
    ent_t e;
    sz  = m_q.size();
    psh = bus.in_valid && (sz < DEPTH);
    uf  = 0;
    if (!m_run) begin
      if (enable && sz > 0) begin
        e = m_q.pop_front();
        m_duty = e.d; m_left = e.r + 1; m_run = 1; m_ph = 0; m_dry = 0;
      end
    end else begin
      if (m_ph == 7) begin
        if (!enable) m_run = 0;
        else if (m_left > 1) m_left--;
        else if (sz > 0) begin
          e = m_q.pop_front();
          m_duty = e.d; m_left = e.r + 1; m_dry = 0;
        end else begin
`ifdef DUTY_HOLD_EN
          uf = !m_dry;
          m_dry = 1;
`else
          uf = 1;
          m_run = 0;
`endif
        end
      end
      m_ph = (m_ph + 1) % 8;
    end
    m_uf = uf;
    if (psh) begin
      e.d = bus.in_duty; e.r = bus.in_repeat;
      m_q.push_back(e);
      if (tx_q.size() > 0) void'(tx_q.pop_front());
    end
  endtask

  task automatic compare_all();
    check("O", int'(O), int'(m_run && m_ph <= m_duty));
    check("S", int'(S), m_duty);
    check("phase", int'(phase), m_ph);
    check("period_end", int'(period_end), int'(m_run && m_ph == 7));
    check("underflow", int'(underflow), int'(m_uf));
    check("level", int'(level), m_q.size());
    check("in_ready", int'(bus.in_ready), int'(m_q.size() < DEPTH));
  endtask

  task automatic drive();
    if (tx_q.size() > 0) begin
      bus.in_valid = 1'b1; bus.in_duty = tx_q[0].d; bus.in_repeat = tx_q[0].r;
    end else begin
      bus.in_valid = 1'b0; bus.in_duty = 3'($urandom_range(7)); bus.in_repeat = 4'($urandom_range(15));
    end
  endtask

  task automatic cycle();
    drive();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push_ent(input int d, input int r);
    ent_t e;
    e.d = 3'(d); e.r = 4'(r);
    tx_q.push_back(e);
  endtask

  initial begin
    logic [15:0] pat;
    int k;
    ent_t e;
    n_checks = 0; n_errors = 0;
    CLEAR = 1'b1; enable = 1'b0;
    bus.in_valid = 1'b0; bus.in_duty = 3'd0; bus.in_repeat = 4'd0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_O", int'(O), 0);
    check("rst_S", int'(S), 0);
    check("rst_level", int'(level), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    CLEAR = 1'b0;

    // Single entry: duty 2, two periods.
    enable = 1'b1;
    push_ent(2, 1);
    run_cycles(2);
    pat = '0;
    for (int i = 0; i < 16; i++) begin
      pat = {pat[14:0], O};
      cycle();
    end
    check("single_pat", int'(pat), 16'hE0E0);
    check("single_uf", int'(underflow), 1);
`ifdef DUTY_HOLD_EN
    check("single_hold_O", int'(O), 1);
`else
    check("single_idle_O", int'(O), 0);
`endif
    enable = 1'b0;
    run_cycles(10);

    // Back-to-back entries with no gap.
    enable = 1'b1;
    push_ent(0, 0); push_ent(7, 0);
    run_cycles(2);
    pat = '0;
    for (int i = 0; i < 16; i++) begin
      pat = {pat[14:0], O};
      cycle();
    end
    check("b2b_pat", int'(pat), 16'h80FF);
    enable = 1'b0;
    run_cycles(10);

    // Fill the FIFO while disabled, then release.
    for (int i = 0; i < 5; i++) push_ent(i, 0);
    run_cycles(6);
    check("full_level", int'(level), 4);
    check("full_ready", int'(bus.in_ready), 0);
    enable = 1'b1;
    cycle();
    check("pop_ready", int'(bus.in_ready), 1);
    cycle();
    check("fifth_level", int'(level), 4);
    run_cycles(50);
    enable = 1'b0;
    run_cycles(10);

    // Enable drop at phase 2 completes the period, keeps queued entries.
    enable = 1'b1;
    push_ent(4, 3); push_ent(1, 0);
    k = 0;
    while (!(m_run && m_ph == 2) && k < 40) begin cycle(); k++; end
    check("wait_ph2", int'(k < 40), 1);
    enable = 1'b0;
    run_cycles(8);
    check("drop_O", int'(O), 0);
    check("drop_level", int'(level), 1);

    // Late push on the phase-7 edge of a dry queue.
    enable = 1'b1;
    k = 0;
    while (!(m_run && m_ph == 7 && m_q.size() == 0 && m_left == 1) && k < 40) begin cycle(); k++; end
    check("wait_late", int'(k < 40), 1);
    push_ent(6, 0);
    cycle();
    check("late_uf", int'(underflow), 1);
    cycle();
`ifndef DUTY_HOLD_EN
    check("late_restart_S", int'(S), 6);
    check("late_restart_ph", int'(phase), 0);
`endif
    run_cycles(20);

    // Asynchronous clear mid-period.
    push_ent(5, 3); push_ent(2, 1); push_ent(3, 0);
    k = 0;
    while (!(m_run && m_ph == 3 && m_q.size() > 0) && k < 60) begin cycle(); k++; end
    check("wait_ph3", int'(k < 60), 1);
    #2 CLEAR = 1'b1;
    #1;
    check("clr_O", int'(O), 0);
    check("clr_level", int'(level), 0);
    check("clr_phase", int'(phase), 0);
    model_reset();
    tx_q.delete();
    bus.in_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    CLEAR = 1'b0;
    compare_all();

    // Randomized traffic including enable drops and maximal repeats.
    enable = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(39) == 0) enable = !enable;
      if (tx_q.size() < 2 && $urandom_range(2) == 0) begin
        e.d = 3'($urandom_range(7));
        e.r = ($urandom_range(15) == 0) ? 4'd15 : 4'($urandom_range(3));
        tx_q.push_back(e);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
